// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Included by the packer and the boot controller top.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    BYTE   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream valid/ready channel from the host/UART side.
// master = byte source, slave = boot controller.
interface imem_boot_ctrl_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/byte_word_packer.sv
// Big-endian 8->32 packer: first byte lands in bits [31:24].
// word_nxt is the full word including the byte on din.
module byte_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        last,
  output logic [31:0] word_nxt
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] cnt;
  logic [23:0]   sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      sr  <= {sr[15:0], din};
    end
  end

  assign last     = (cnt == CW'(BYTES_PER_WORD - 1));
  assign word_nxt = {sr, din};

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: length header + big-endian words into imem,
// CPU held until the load finishes.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_boot_ctrl_if.slave   rx,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   words_loaded
);

  state_t state_q, state_d;

  logic [15:0]       n_q;
  logic [15:0]       n_nxt;
  logic [15:0]       wc_inc;
  logic [ADDR_W-1:0] word_cnt;
  logic [31:0]       pk_word;
  logic xfer, pk_last;
  logic hdr_hi, hdr_lo, pk_clr, pk_en;
  logic wr_go, wr_end, clr_all;

  assign rx.rx_ready = (state_q == LEN_HI) |
                       (state_q == LEN_LO) |
                       (state_q == BYTE);
  assign xfer   = rx.rx_valid & rx.rx_ready;
  assign n_nxt  = {n_q[15:8], rx.rx_data};
  assign wc_inc = 16'(word_cnt) + 16'd1;

  byte_word_packer u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pk_clr),
    .en       (pk_en),
    .din      (rx.rx_data),
    .last     (pk_last),
    .word_nxt (pk_word)
  );

  always_comb begin
    state_d = state_q;
    hdr_hi  = 1'b0;
    hdr_lo  = 1'b0;
    pk_clr  = 1'b0;
    pk_en   = 1'b0;
    wr_go   = 1'b0;
    wr_end  = 1'b0;
    clr_all = 1'b0;
    unique case (state_q)
      LEN_HI: if (xfer) begin
        hdr_hi  = 1'b1;
        state_d = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        hdr_lo = 1'b1;
        if (n_nxt == 16'd0) begin
          state_d = DONE;
        end else if ({16'd0, n_nxt} > 32'(DEPTH)) begin
          state_d = ERR;
        end else begin
          state_d = BYTE;
          pk_clr  = 1'b1;
        end
      end
      BYTE: if (xfer) begin
        pk_en = 1'b1;
        if (pk_last) begin
          wr_go   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_end  = 1'b1;
        state_d = (wc_inc == n_q) ? DONE : BYTE;
      end
      DONE, ERR: if (reload) begin
        clr_all = 1'b1;
        state_d = LEN_HI;
      end
      default: state_d = LEN_HI;
    endcase
  end

  // Status flags follow the next state so they move on the entry/exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LEN_HI;
      n_q          <= '0;
      word_cnt     <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cpu_run      <= 1'b0;
      boot_done    <= 1'b0;
      boot_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_we  <= wr_go;
      if (wr_go) begin
        mem_waddr <= word_cnt;
        mem_wdata <= pk_word;
      end
      if (hdr_hi) n_q[15:8] <= rx.rx_data;
      if (hdr_lo) n_q[7:0]  <= rx.rx_data;
      if (pk_clr)
        word_cnt <= '0;
      else if (wr_end && state_d == BYTE)
        word_cnt <= word_cnt + 1'b1;
      if (clr_all)
        words_loaded <= '0;
      else if (wr_end)
        words_loaded <= wc_inc[ADDR_W:0];
      cpu_run   <= (state_d == DONE);
      boot_done <= (state_d == DONE);
      boot_err  <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: vector table, directed corner
// sequences and random loads against a stream-level model.
module tb_imem_boot_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reload = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        boot_done;
  logic        boot_err;
  logic [10:0] words_loaded;

  int checks = 0;
  int errors = 0;

  imem_boot_ctrl_if bif ();

  imem_boot_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (bif),
    .reload       (reload),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .boot_done    (boot_done),
    .boot_err     (boot_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk)
    if (rst_n && mem_we)
      wq.push_back(wr_t'{a: mem_waddr, d: mem_wdata});

  typedef struct packed {
    logic [3:0]  len;
    logic [95:0] b;
    logic [1:0]  nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        done;
    logic        err;
    logic [10:0] wl;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) begin
      @(negedge clk);
      bif.rx_valid = 1'b0;
    end
    @(negedge clk);
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    k = 0;
    while (!bif.rx_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (k == 64) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h not accepted", b);
      bif.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bif.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bif.rx_valid = 1'b0;
    reload = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    wq.delete();
  endtask

  task automatic chk_status(input string nm, input logic done,
                            input logic err, input int wl);
    chk({nm, "_done"}, boot_done, done);
    chk({nm, "_err"}, boot_err, err);
    chk({nm, "_run"}, cpu_run, done);
    chk({nm, "_wl"}, words_loaded, 64'(wl));
    chk({nm, "_rdy"}, bif.rx_ready, 0);
  endtask

  initial begin
    logic [7:0]  s[$];
    logic [31:0] ew[$];
    logic [31:0] w;
    int n, bad;

    bif.rx_data  = 8'h00;
    bif.rx_valid = 1'b0;

    tbl[0] = '{len: 10,
      b: {80'h0002_2002_0005_2003_0003, 16'h0},
      nwr: 2, w0: 32'h2002_0005, w1: 32'h2003_0003,
      done: 1, err: 0, wl: 2};
    tbl[1] = '{len: 2, b: {16'h0000, 80'h0},
      nwr: 0, w0: 0, w1: 0, done: 1, err: 0, wl: 0};
    tbl[2] = '{len: 2, b: {16'h0401, 80'h0},
      nwr: 0, w0: 0, w1: 0, done: 0, err: 1, wl: 0};
    tbl[3] = '{len: 6, b: {48'h0001_dead_beef, 48'h0},
      nwr: 1, w0: 32'hdead_beef, w1: 0,
      done: 1, err: 0, wl: 1};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_we", mem_we, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_done", boot_done, 0);
    chk("rst_err", boot_err, 0);
    chk("rst_wl", words_loaded, 0);
    chk("rst_rdy", bif.rx_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_reset();
      for (int j = 0; j < int'(tbl[i].len); j++)
        send_byte(tbl[i].b[95-8*j -: 8], 0);
      if (tbl[i].nwr != 0) begin
        chk("t_we_hi", mem_we, 1);
        chk("t_rdy_wr", bif.rx_ready, 0);
        @(posedge clk);
        #1;
        chk("t_we_lo", mem_we, 0);
        @(posedge clk);
        #1;
        chk("t_done_t2", boot_done, 1);
      end
      repeat (3) @(negedge clk);
      chk("t_nwr", wq.size(), 64'(tbl[i].nwr));
      if (tbl[i].nwr >= 1) begin
        chk("t_a0", wq.size() > 0 ? wq[0].a : 10'h3ff, 0);
        chk("t_w0", wq.size() > 0 ? wq[0].d : 32'h0, tbl[i].w0);
      end
      if (tbl[i].nwr >= 2) begin
        chk("t_a1", wq.size() > 1 ? wq[1].a : 10'h3ff, 1);
        chk("t_w1", wq.size() > 1 ? wq[1].d : 32'h0, tbl[i].w1);
      end
      chk_status("t", tbl[i].done, tbl[i].err, int'(tbl[i].wl));
    end

    // Error header then reload back to LEN_HI.
    do_reset();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    chk("err_flag", boot_err, 1);
    chk("err_rdy", bif.rx_ready, 0);
    chk("err_run", cpu_run, 0);
    pulse_reload();
    chk("err_clr", boot_err, 0);
    chk("err_rdy1", bif.rx_ready, 1);

    // Toggling valid, ignored reload mid-load, byte held over WRITE.
    do_reset();
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    pulse_reload();
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'h56, 1);
    send_byte(8'h78, 1);
    chk("hold_we", mem_we, 1);
    chk("hold_rdy_wr", bif.rx_ready, 0);
    bad = 0;
    bif.rx_data  = 8'h9a;
    bif.rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bif.rx_ready) bad++;
    end
    bif.rx_valid = 1'b0;
    chk("hold_blocked", bad, 0);
    chk("hold_nwr", wq.size(), 1);
    chk("hold_w0", wq.size() > 0 ? wq[0].d : 32'h0, 32'h1234_5678);
    chk_status("hold", 1, 0, 1);

    // Async reset mid-load, then a fresh load.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int j = 0; j < 6; j++) send_byte(8'h11 * (j + 1), 0);
    chk("mid_wl", words_loaded, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wl", words_loaded, 0);
    chk("ar_wdata", mem_wdata, 0);
    chk("ar_waddr", mem_waddr, 0);
    chk("ar_we", mem_we, 0);
    chk("ar_rdy", bif.rx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    s = '{8'h00, 8'h01, 8'haa, 8'hbb, 8'hcc, 8'hdd};
    foreach (s[j]) send_byte(s[j], 0);
    repeat (3) @(negedge clk);
    chk("ar_nwr", wq.size(), 1);
    chk("ar_w0", wq.size() > 0 ? wq[0].d : 32'h0, 32'haabb_ccdd);
    chk_status("ar", 1, 0, 1);

    // Reload from DONE holds the CPU on the next cycle.
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    chk("rl_run", cpu_run, 0);
    chk("rl_done", boot_done, 0);
    chk("rl_wl", words_loaded, 0);
    chk("rl_rdy", bif.rx_ready, 1);
    @(negedge clk);
    reload = 1'b0;
    wq.delete();
    s = '{8'h00, 8'h01, 8'h00, 8'h43, 8'h08, 8'h20};
    foreach (s[j]) send_byte(s[j], 0);
    repeat (3) @(negedge clk);
    chk("rl_nwr", wq.size(), 1);
    chk("rl_w0", wq.size() > 0 ? wq[0].d : 32'h0, 32'h0043_0820);
    chk_status("rl", 1, 0, 1);

    // Random loads against the stream-level model.
    for (int it = 0; it < 24; it++) begin
      if (it % 3 == 0) do_reset();
      else pulse_reload();
      n = $urandom_range(0, 9);
      if (n == 0) n = 0;
      else if (n == 1) n = $urandom_range(DEPTH + 1, 65535);
      else n = $urandom_range(1, 6);
      s.delete();
      ew.delete();
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      if (n <= DEPTH)
        for (int k = 0; k < n; k++) begin
          w = $urandom;
          ew.push_back(w);
          for (int m = 3; m >= 0; m--) s.push_back(8'(w >> (8 * m)));
        end
      foreach (s[j]) send_byte(s[j], $urandom_range(0, 2));
      repeat (4) @(negedge clk);
      chk("rnd_nwr", wq.size(), 64'(ew.size()));
      bad = 0;
      foreach (ew[k])
        if (k >= wq.size() || wq[k].d !== ew[k] || wq[k].a !== 10'(k))
          bad++;
      chk("rnd_data", bad, 0);
      chk_status("rnd", n <= DEPTH, n > DEPTH, n <= DEPTH ? n : 0);
    end

    // Full-depth load: N == DEPTH is legal, last address is DEPTH-1.
    do_reset();
    ew.delete();
    send_byte(8'(DEPTH >> 8), 0);
    send_byte(8'(DEPTH), 0);
    for (int k = 0; k < DEPTH; k++) begin
      w = $urandom;
      ew.push_back(w);
      for (int m = 3; m >= 0; m--) send_byte(8'(w >> (8 * m)), 0);
    end
    repeat (4) @(negedge clk);
    chk("big_nwr", wq.size(), DEPTH);
    chk("big_last_a", wq.size() == DEPTH ? wq[DEPTH-1].a : 10'h0, DEPTH - 1);
    bad = 0;
    foreach (ew[k])
      if (k >= wq.size() || wq[k].d !== ew[k]) bad++;
    chk("big_data", bad, 0);
    chk_status("big", 1, 0, DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
